// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types, widths and defaults for the snake game engine
package snake_pkg;

    localparam int GRID_W_DEF  = 16;
    localparam int GRID_H_DEF  = 16;
    localparam int MAX_LEN_DEF = 32;

    localparam int XW = 4;   // column coordinate width
    localparam int YW = 4;   // row coordinate width
    localparam int LW = 6;   // length / index width (holds 0..MAX_LEN)

    typedef enum logic [1:0] {UP = 2'd0, DN = 2'd1, LT = 2'd2, RT = 2'd3} dir_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } pos_t;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} eng_state_t;

    function automatic dir_t reverse_dir(input dir_t d);
        case (d)
            UP:      return DN;
            DN:      return UP;
            LT:      return RT;
            default: return LT;
        endcase
    endfunction

endpackage

// File: rtl/snake_move_tick.sv
// rtl/snake_move_tick.sv - difficulty-selected move tick divider with enable and clear
// Ports: clk, rst (async, active-high), clear (restart count), enable (count while high),
//        difficulty (0 normal, 1 hard; sampled on clear and at each wrap), tick (terminal count).
module snake_move_tick #(
    parameter int TICK_NORMAL = 5000000,
    parameter int TICK_HARD   = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic difficulty,
    output logic tick
);
    localparam int TMAX = (TICK_NORMAL > TICK_HARD) ? TICK_NORMAL : TICK_HARD;
    localparam int CW   = $clog2(TMAX + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] limit;
    logic [CW-1:0] limit_sel;

    assign limit_sel = difficulty ? CW'(TICK_HARD) : CW'(TICK_NORMAL);
    assign tick      = enable && (cnt == limit - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            limit <= CW'(TICK_NORMAL);
        end else if (clear) begin
            cnt   <= '0;
            limit <= limit_sel;
        end else if (enable) begin
            if (cnt == limit - CW'(1)) begin
                cnt   <= '0;
                limit <= limit_sel;   // period only changes on a wrap
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/snake_game_engine.sv
// rtl/snake_game_engine.sv - snake motion, body buffer, food placement and collision engine
// Ports: clk, rst (async, active-high); rst_game/en_s/en_f/stage/difficulty from the game FSM;
//        btn_up/dn/lt/rt active-low; food_collision/game_over 1-cycle pulses; head/food
//        coordinates, food_valid, length, score; rd_idx -> rd_x/rd_y/rd_valid display port.
// Optional build macro: WRAP_WALLS_EN (edges wrap, only self-hit ends the game).
module snake_game_engine
    import snake_pkg::*;
#(
    parameter int          GRID_W      = GRID_W_DEF,
    parameter int          GRID_H      = GRID_H_DEF,
    parameter int          MAX_LEN     = MAX_LEN_DEF,
    parameter int          TICK_NORMAL = 5000000,
    parameter int          TICK_HARD   = 2500000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rst_game,
    input  logic          en_s,
    input  logic          en_f,
    input  logic          stage,
    input  logic          difficulty,
    input  logic          btn_up,
    input  logic          btn_dn,
    input  logic          btn_lt,
    input  logic          btn_rt,
    output logic          food_collision,
    output logic          game_over,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [XW-1:0] food_x,
    output logic [YW-1:0] food_y,
    output logic          food_valid,
    output logic [LW-1:0] length,
    output logic [7:0]    score,
    input  logic [LW-1:0] rd_idx,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic          rd_valid
);
    localparam int IW = $clog2(MAX_LEN);

    eng_state_t  state;
    pos_t        body [MAX_LEN];
    logic [LW-1:0] len;
    dir_t        dir, pend, btn_dir;
    logic [15:0] lfsr;
    logic        placing;
    pos_t        food, nxt, cand;
    logic        btn_any, at_edge, wall_hit, self_hit, cand_on_body, tick, move;

    snake_move_tick #(.TICK_NORMAL(TICK_NORMAL), .TICK_HARD(TICK_HARD)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .clear      (rst_game),
        .enable     (state == RUN && stage),
        .difficulty (difficulty),
        .tick       (tick)
    );

    assign move = tick && (state == RUN);

    always_comb begin
        btn_any = !(btn_up && btn_dn && btn_lt && btn_rt);
        if (!btn_up)      btn_dir = UP;
        else if (!btn_dn) btn_dir = DN;
        else if (!btn_lt) btn_dir = LT;
        else              btn_dir = RT;

        // nxt always holds the wrapped coordinate; at_edge says whether we crossed a border
        nxt     = body[0];
        at_edge = 1'b0;
        case (pend)
            UP: if (body[0].y == '0) begin at_edge = 1'b1; nxt.y = YW'(GRID_H - 1); end
                else nxt.y = body[0].y - YW'(1);
            DN: if (body[0].y == YW'(GRID_H - 1)) begin at_edge = 1'b1; nxt.y = '0; end
                else nxt.y = body[0].y + YW'(1);
            LT: if (body[0].x == '0) begin at_edge = 1'b1; nxt.x = XW'(GRID_W - 1); end
                else nxt.x = body[0].x - XW'(1);
            default: if (body[0].x == XW'(GRID_W - 1)) begin at_edge = 1'b1; nxt.x = '0; end
                else nxt.x = body[0].x + XW'(1);
        endcase

        // the tail segment moves away during this step, so it cannot be hit
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(len) - 1 && body[i] == nxt) self_hit = 1'b1;

        cand.x = XW'(int'(lfsr[7:0]) % GRID_W);
        cand.y = YW'(int'(lfsr[15:8]) % GRID_H);
        cand_on_body = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(len) && body[i] == cand) cand_on_body = 1'b1;
    end

`ifdef WRAP_WALLS_EN
    assign wall_hit = 1'b0;
`else
    assign wall_hit = at_edge;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            for (int i = 0; i < MAX_LEN; i++) body[i] <= '0;
            len            <= '0;
            score          <= '0;
            dir            <= RT;
            pend           <= RT;
            lfsr           <= LFSR_SEED;
            placing        <= 1'b0;
            food           <= '0;
            food_valid     <= 1'b0;
            food_collision <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            food_collision <= 1'b0;
            game_over      <= 1'b0;
            if (rst_game) begin
                state      <= en_s ? RUN : IDLE;
                for (int i = 1; i < MAX_LEN; i++) body[i] <= '0;
                body[0]    <= '{x: XW'(GRID_W / 2), y: YW'(GRID_H / 2)};
                len        <= LW'(1);
                score      <= '0;
                food_valid <= 1'b0;
                placing    <= 1'b0;
                dir        <= RT;
                pend       <= RT;
            end else begin
                if (state == RUN && btn_any && !(len > LW'(1) && btn_dir == reverse_dir(dir)))
                    pend <= btn_dir;

                if (move) begin
                    if (wall_hit || self_hit) begin
                        game_over <= 1'b1;
                        state     <= DEAD;
                    end else begin
                        for (int i = MAX_LEN - 1; i > 0; i--) body[i] <= body[i-1];
                        body[0] <= nxt;
                        dir     <= pend;
                        if (food_valid && nxt == food) begin
                            if (len != LW'(MAX_LEN)) len <= len + LW'(1);
                            if (score != 8'd255) score <= score + 8'd1;
                            food_valid     <= 1'b0;
                            food_collision <= 1'b1;
                        end
                    end
                end

                // placement: step the LFSR every cycle until a candidate lands off the body
                if (en_f) begin
                    placing    <= 1'b1;
                    food_valid <= 1'b0;
                end else if (placing) begin
                    lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
                    if (!cand_on_body) begin
                        food       <= cand;
                        food_valid <= 1'b1;
                        placing    <= 1'b0;
                    end
                end
            end
        end
    end

    assign head_x   = body[0].x;
    assign head_y   = body[0].y;
    assign food_x   = food.x;
    assign food_y   = food.y;
    assign length   = len;
    assign rd_valid = rd_idx < len;
    assign rd_x     = rd_valid ? body[rd_idx[IW-1:0]].x : '0;
    assign rd_y     = rd_valid ? body[rd_idx[IW-1:0]].y : '0;

endmodule

// File: tb/tb_snake_game_engine.sv
// tb/tb_snake_game_engine.sv - scoreboard testbench for snake_game_engine
module tb_snake_game_engine;
    import snake_pkg::*;

    localparam int TN = 4;
    localparam int TH = 2;
    localparam int GW = 16;
    localparam int GH = 16;

    logic clk = 1'b0, rst = 1'b1, rst_game = 1'b0, en_s = 1'b0, en_f = 1'b0;
    logic stage = 1'b0, difficulty = 1'b0;
    logic btn_up = 1'b1, btn_dn = 1'b1, btn_lt = 1'b1, btn_rt = 1'b1;
    logic food_collision, game_over, food_valid, rd_valid;
    logic [XW-1:0] head_x, food_x, rd_x;
    logic [YW-1:0] head_y, food_y, rd_y;
    logic [LW-1:0] length, rd_idx = '0;
    logic [7:0] score;

    int checks = 0, failures = 0;

    typedef struct {pos_t head; int len; int score; bit go; bit fc;} exp_t;
    exp_t q[$];
    pos_t fq[$];
    int   tq[$];

    pos_t mb [32];
    int   mlen, mscore;
    dir_t mdir, mpend;
    logic [15:0] mlfsr;
    pos_t mfood;
    bit   mfv, mdead;

    snake_game_engine #(.TICK_NORMAL(TN), .TICK_HARD(TH)) dut (
        .clk(clk), .rst(rst), .rst_game(rst_game), .en_s(en_s), .en_f(en_f),
        .stage(stage), .difficulty(difficulty),
        .btn_up(btn_up), .btn_dn(btn_dn), .btn_lt(btn_lt), .btn_rt(btn_rt),
        .food_collision(food_collision), .game_over(game_over),
        .head_x(head_x), .head_y(head_y), .food_x(food_x), .food_y(food_y),
        .food_valid(food_valid), .length(length), .score(score),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic dir_t rev(input dir_t d);
        case (d)
            UP: rev = DN;
            DN: rev = UP;
            LT: rev = RT;
            default: rev = LT;
        endcase
    endfunction

    function automatic dir_t perp(input dir_t d, input pos_t h);
        if (d == LT || d == RT) perp = (h.y != 4'd0) ? UP : DN;
        else perp = (h.x != 4'd0) ? LT : RT;
    endfunction

    function automatic dir_t pick(input pos_t t);
        pos_t h = mb[0];
        if (t.x != h.x) begin
            if (t.x > h.x && !(mlen > 1 && mdir == LT)) return RT;
            if (t.x < h.x && !(mlen > 1 && mdir == RT)) return LT;
        end
        if (t.y != h.y) begin
            if (t.y > h.y && !(mlen > 1 && mdir == UP)) return DN;
            if (t.y < h.y && !(mlen > 1 && mdir == DN)) return UP;
        end
        return perp(mdir, h);
    endfunction

    task automatic set_btns(input dir_t d, input bit on);
        btn_up = 1'b1; btn_dn = 1'b1; btn_lt = 1'b1; btn_rt = 1'b1;
        if (on) case (d)
            UP: btn_up = 1'b0;
            DN: btn_dn = 1'b0;
            LT: btn_lt = 1'b0;
            default: btn_rt = 1'b0;
        endcase
    endtask

    task automatic model_restart();
        for (int i = 0; i < 32; i++) mb[i] = '0;
        mb[0].x = 4'd8; mb[0].y = 4'd8;
        mlen = 1; mscore = 0; mdir = RT; mpend = RT; mfv = 0; mdead = 0;
    endtask

    task automatic m_move(output exp_t e);
        pos_t n;
        bit at_edge, hit;
        e.go = 0; e.fc = 0;
        if (!mdead) begin
            n = mb[0]; at_edge = 0;
            case (mpend)
                UP: if (n.y == 4'd0) begin at_edge = 1; n.y = 4'd15; end else n.y = n.y - 4'd1;
                DN: if (n.y == 4'd15) begin at_edge = 1; n.y = 4'd0; end else n.y = n.y + 4'd1;
                LT: if (n.x == 4'd0) begin at_edge = 1; n.x = 4'd15; end else n.x = n.x - 4'd1;
                default: if (n.x == 4'd15) begin at_edge = 1; n.x = 4'd0; end else n.x = n.x + 4'd1;
            endcase
`ifdef WRAP_WALLS_EN
            at_edge = 0;
`endif
            hit = at_edge;
            for (int i = 0; i < mlen - 1; i++) if (mb[i] == n) hit = 1;
            if (hit) begin
                mdead = 1; e.go = 1;
            end else begin
                for (int i = 31; i > 0; i--) mb[i] = mb[i-1];
                mb[0] = n; mdir = mpend;
                if (mfv && n == mfood) begin
                    if (mlen < 32) mlen++;
                    if (mscore < 255) mscore++;
                    mfv = 0; e.fc = 1;
                end
            end
        end
        e.head = mb[0]; e.len = mlen; e.score = mscore;
    endtask

    task automatic restart();
        rst_game = 1'b1; en_s = 1'b1;
        @(negedge clk);
        rst_game = 1'b0; en_s = 1'b0;
        model_restart();
    endtask

    task automatic move_one(input dir_t b, input bit press);
        exp_t e;
        pos_t pre = mb[0];
        bit was_dead = mdead;
        if (press && !mdead && (mlen == 1 || b != rev(mdir))) mpend = b;
        m_move(e);
        q.push_back(e);
        set_btns(b, press);
        stage = 1'b1;
        repeat (TN - 1) @(negedge clk);
        checks++;
        if (!was_dead && (head_x !== pre.x || head_y !== pre.y)) begin
            failures++;
            $display("FAIL early_move got=(%0d,%0d) exp=(%0d,%0d)", head_x, head_y, pre.x, pre.y);
        end
        @(negedge clk);
        stage = 1'b0;
        set_btns(b, 1'b0);
        e = q.pop_front();
        checks += 5;
        if (head_x !== e.head.x || head_y !== e.head.y) begin
            failures++;
            $display("FAIL move_head got=(%0d,%0d) exp=(%0d,%0d)", head_x, head_y, e.head.x, e.head.y);
        end
        if (length !== LW'(e.len)) begin
            failures++; $display("FAIL move_length got=%0d exp=%0d", length, e.len);
        end
        if (score !== 8'(e.score)) begin
            failures++; $display("FAIL move_score got=%0d exp=%0d", score, e.score);
        end
        if (game_over !== e.go) begin
            failures++; $display("FAIL move_game_over got=%0d exp=%0d", game_over, e.go);
        end
        if (food_collision !== e.fc) begin
            failures++; $display("FAIL move_food_collision got=%0d exp=%0d", food_collision, e.fc);
        end
    endtask

    task automatic steer_to(input pos_t t);
        int n = 0;
        while (!mdead && mb[0] != t && n < 40) begin
            move_one(pick(t), 1'b1);
            n++;
        end
        checks++;
        if (head_x !== t.x || head_y !== t.y) begin
            failures++;
            $display("FAIL steer_target got=(%0d,%0d) exp=(%0d,%0d)", head_x, head_y, t.x, t.y);
        end
    endtask

    task automatic place_food();
        pos_t c, ef;
        int tries = 0, w = 0, et;
        bit hit;
        do begin
            c.x = mlfsr[3:0]; c.y = mlfsr[11:8];
            mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
            tries++;
            hit = 0;
            for (int i = 0; i < mlen; i++) if (mb[i] == c) hit = 1;
        end while (hit && tries < 1000);
        fq.push_back(c); tq.push_back(tries);
        mfood = c; mfv = 1;
        en_f = 1'b1;
        @(negedge clk);
        en_f = 1'b0;
        while (food_valid !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        ef = fq.pop_front(); et = tq.pop_front();
        checks += 3;
        if (food_valid !== 1'b1) begin
            failures++; $display("FAIL place_valid got=%0d exp=1 after %0d cycles", food_valid, w);
        end
        if (w != et) begin
            failures++; $display("FAIL place_tries got=%0d exp=%0d", w, et);
        end
        if (food_x !== ef.x || food_y !== ef.y) begin
            failures++;
            $display("FAIL place_pos got=(%0d,%0d) exp=(%0d,%0d)", food_x, food_y, ef.x, ef.y);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mlfsr = 16'hACE1;
        model_restart();
        @(negedge clk);
        checks += 4;
        if ({head_x, head_y} !== 8'h00) begin
            failures++; $display("FAIL reset_head got=(%0d,%0d) exp=(0,0)", head_x, head_y);
        end
        if (length !== '0 || score !== 8'd0) begin
            failures++; $display("FAIL reset_len_score got=%0d/%0d exp=0/0", length, score);
        end
        if (food_valid !== 1'b0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valids got=%0d/%0d exp=0/0", food_valid, rd_valid);
        end
        if (game_over !== 1'b0 || food_collision !== 1'b0) begin
            failures++; $display("FAIL reset_pulses got=%0d/%0d exp=0/0", game_over, food_collision);
        end
    endtask

    task automatic test_restart_move();
        restart();
        checks += 3;
        if (head_x !== 4'd8 || head_y !== 4'd8 || length !== LW'(1)) begin
            failures++;
            $display("FAIL restart_head got=(%0d,%0d) len=%0d exp=(8,8) len=1", head_x, head_y, length);
        end
        if (rd_valid !== 1'b1 || rd_x !== 4'd8 || rd_y !== 4'd8) begin
            failures++; $display("FAIL restart_rd got=%0d (%0d,%0d) exp=1 (8,8)", rd_valid, rd_x, rd_y);
        end
        repeat (10) @(negedge clk);
        if (head_x !== 4'd8) begin
            failures++; $display("FAIL stage_freeze got=%0d exp=8", head_x);
        end
        move_one(RT, 1'b0);
        move_one(UP, 1'b1);
    endtask

    task automatic test_hard();
        difficulty = 1'b1;
        restart();
        stage = 1'b1;
        repeat (TH) @(negedge clk);
        difficulty = 1'b0;
        checks += 3;
        if (head_x !== 4'd9) begin
            failures++; $display("FAIL hard_first got=%0d exp=9", head_x);
        end
        repeat (TH) @(negedge clk);
        if (head_x !== 4'd10) begin
            failures++; $display("FAIL hard_second got=%0d exp=10", head_x);
        end
        repeat (TN) @(negedge clk);
        if (head_x !== 4'd11) begin
            failures++; $display("FAIL normal_after_wrap got=%0d exp=11", head_x);
        end
        stage = 1'b0;
    endtask

    task automatic test_wall();
        bit bad = 0;
        pos_t h;
        restart();
        for (int i = 0; i < 8; i++) move_one(RT, 1'b0);
        if (mdead) begin
            h = mb[0];
            stage = 1'b1;
            for (int i = 0; i < 3 * TN; i++) begin
                @(negedge clk);
                if (game_over !== 1'b0 || head_x !== h.x || head_y !== h.y) bad = 1;
            end
            stage = 1'b0;
            checks++;
            if (bad) begin
                failures++; $display("FAIL dead_hold got=moved_or_pulsed exp=held (%0d,%0d)", h.x, h.y);
            end
        end
    endtask

    task automatic test_reversal();
        restart();
        move_one(RT, 1'b0);
        move_one(LT, 1'b1);
        move_one(LT, 1'b1);
    endtask

    task automatic test_food_eat();
        pos_t c0;
        restart();
        c0.x = mlfsr[3:0]; c0.y = mlfsr[11:8];
        steer_to(c0);
        place_food();
        steer_to(mfood);
        rd_idx = LW'(1);
        #1;
        checks += 2;
        if (rd_valid !== 1'b1 || rd_x !== mb[1].x || rd_y !== mb[1].y) begin
            failures++;
            $display("FAIL rd_seg1 got=%0d (%0d,%0d) exp=1 (%0d,%0d)", rd_valid, rd_x, rd_y, mb[1].x, mb[1].y);
        end
        rd_idx = LW'(2);
        #1;
        if (rd_valid !== 1'b0) begin
            failures++; $display("FAIL rd_beyond got=%0d exp=0", rd_valid);
        end
        rd_idx = '0;
    endtask

    task automatic test_mid_restart();
        place_food();
        stage = 1'b1;
        repeat (2) @(negedge clk);
        restart();
        stage = 1'b0;
        checks += 3;
        if (length !== LW'(1) || score !== 8'd0) begin
            failures++; $display("FAIL midrst_len_score got=%0d/%0d exp=1/0", length, score);
        end
        if (food_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_food_valid got=%0d exp=0", food_valid);
        end
        if (game_over !== 1'b0 || food_collision !== 1'b0) begin
            failures++; $display("FAIL midrst_pulses got=%0d/%0d exp=0/0", game_over, food_collision);
        end
    endtask

    task automatic test_self_hit();
        dir_t seq [4];
        restart();
        for (int k = 0; k < 4; k++) begin
            place_food();
            steer_to(mfood);
        end
        seq[0] = perp(mdir, mb[0]);
        seq[1] = rev(mdir);
        seq[2] = rev(seq[0]);
        seq[3] = mdir;
        for (int k = 0; k < 4; k++) if (!mdead) move_one(seq[k], 1'b1);
        checks++;
        if (length !== LW'(5) || score !== 8'd4) begin
            failures++; $display("FAIL self_hit_len_score got=%0d/%0d exp=5/4", length, score);
        end
    endtask

    initial begin
        test_reset();
        test_restart_move();
        test_hard();
        test_wall();
        test_reversal();
        test_food_eat();
        test_mid_restart();
        test_self_hit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
